// File: rtl/bcd_to_binary.sv
// ---------------------------------------------------------------------------
// bcd_to_binary
//
// Sequential converter from four packed BCD digits (0000-9999) to a 14-bit
// unsigned binary value using reverse double dabble. Each iteration shifts
// the 30-bit working register {bcd[15:0], bin[13:0]} right by one bit. It
// then subtracts 3 from every BCD nibble that reads 8 or more. After 14
// iterations the bin field holds the binary value.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   start          conversion request, sampled only while idle
//   bcd_thousands  most significant BCD digit
//   bcd_hundreds   BCD digit
//   bcd_tens       BCD digit
//   bcd_units      least significant BCD digit
//   binary_out     result, held stable between conversions
//   busy           high while a conversion is in progress
//   done           one-cycle pulse when binary_out/error are updated
//   error          last accepted request contained a digit > 9
// ---------------------------------------------------------------------------
module bcd_to_binary (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  bcd_thousands,
   input  logic [3:0]  bcd_hundreds,
   input  logic [3:0]  bcd_tens,
   input  logic [3:0]  bcd_units,
   output logic [13:0] binary_out,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int BIN_W    = 14;
   localparam int DIGITS   = 4;
   localparam int WORK_W   = BIN_W + 4 * DIGITS;
   localparam logic [3:0] LAST_ITER = 4'd13;

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   state_t              state, state_next;
   logic [WORK_W-1:0]   work, work_next;
   logic [3:0]          iter, iter_next;
   // Set for one cycle after a request with a non-decimal digit. The error
   // response then appears one cycle later without a third FSM state.
   logic                invalid_pend, invalid_pend_next;

   logic [BIN_W-1:0]    binary_next;
   logic                busy_next;
   logic                done_next;
   logic                error_next;

   logic                digits_ok;
   logic [WORK_W-1:0]   shifted;
   logic [WORK_W-1:0]   corrected;

   assign digits_ok = (bcd_thousands <= 4'd9) && (bcd_hundreds <= 4'd9) &&
                      (bcd_tens      <= 4'd9) && (bcd_units    <= 4'd9);

   // One reverse double dabble step: shift right, then correct each digit.
   // A nibble is tested against 8 before subtracting 3, so it cannot
   // underflow.
   always_comb begin
      shifted   = work >> 1;
      corrected = shifted;
      for (int i = 0; i < DIGITS; i++) begin
         if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
            corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
         end
      end
   end

   // Next-state and output logic.
   // NOTE: every signal gets a hold/default value before the case statement.
   // A branch that forgets a signal then cannot infer a latch.
   always_comb begin
      state_next        = state;
      work_next         = work;
      iter_next         = iter;
      invalid_pend_next = 1'b0;
      binary_next       = binary_out;
      busy_next         = busy;
      done_next         = 1'b0;
      error_next        = error;

      // Deferred response to an earlier non-decimal request.
      if (invalid_pend) begin
         binary_next = '0;
         error_next  = 1'b1;
         done_next   = 1'b1;
      end

      unique case (state)
         IDLE: begin
            if (start) begin
               if (digits_ok) begin
                  work_next  = {bcd_thousands, bcd_hundreds, bcd_tens,
                                bcd_units, {BIN_W{1'b0}}};
                  iter_next  = 4'd0;
                  busy_next  = 1'b1;
                  state_next = CONV;
               end else begin
                  invalid_pend_next = 1'b1;
               end
            end
         end

         CONV: begin
            work_next = corrected;
            iter_next = iter + 4'd1;
            if (iter == LAST_ITER) begin
               binary_next = corrected[BIN_W-1:0];
               error_next  = 1'b0;
               done_next   = 1'b1;
               busy_next   = 1'b0;
               state_next  = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Control state and registered outputs.
   // NOTE: sequential state uses non-blocking assignments only. All
   // registers then update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         iter         <= 4'd0;
         invalid_pend <= 1'b0;
         binary_out   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= state_next;
         iter         <= iter_next;
         invalid_pend <= invalid_pend_next;
         binary_out   <= binary_next;
         busy         <= busy_next;
         done         <= done_next;
         error        <= error_next;
      end
   end

   // NOTE: the working register is deliberately left without a reset. It is
   // fully loaded on every accepted start before anything reads it, so a
   // reset would only add fan-out.
   always_ff @(posedge clk) begin
      work <= work_next;
   end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential converter from four packed BCD digits (0000–9999) to a 14-bit unsigned binary value, using reverse double dabble (shift right, then subtract 3 from any digit ≥ 8). It is the inverse of the combinational binary-to-BCD path. It sits between keypad/display-side BCD entry and the binary datapath. A start/busy/done handshake frames each conversion, and it flags non-decimal digits.

## Interface

- Parameters: none. Widths are fixed: 4 digits, 14-bit result (9999 < 2^14).
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only while idle
- bcd_thousands  input  4  most significant BCD digit
- bcd_hundreds  input  4  BCD digit
- bcd_tens  input  4  BCD digit
- bcd_units  input  4  least significant BCD digit
- binary_out  output  14  result; held stable between conversions
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when binary_out/error are updated
- error  output  1  last accepted request contained a digit > 9

## Operation

- FSM states: IDLE, CONV. done is a registered pulse, not a state.
- Working register: 30 bits, {bcd[15:0], bin[13:0]}. It also has a 4-bit iteration counter (0..13).
- In IDLE, start=1 with all digits ≤ 9:
  - load the register with {thousands, hundreds, tens, units, 14'b0}
  - clear the counter, go to CONV, busy=1
- In IDLE, start=1 with any digit > 9:
  - no conversion runs
  - next cycle: binary_out=0, error=1, done=1; state stays IDLE
- Each CONV cycle performs one iteration:
  - shift the whole 30-bit register right by 1
  - then, for each of the 4 digit nibbles independently, if the nibble ≥ 8, subtract 3
  - increment the counter
- After the 14th iteration (counter=13):
  - binary_out ← bin field (post-shift/correct value)
  - error ← 0, done=1 for one cycle, busy ← 0, return to IDLE
- start is ignored while busy=1. The input digits are not re-sampled during CONV, so they may change freely after the start cycle.
- error holds its value until the next accepted start produces a new result.
- binary_out holds its last value until the next done.

## Timing

- Reset values: binary_out=0, busy=0, done=0, error=0, state=IDLE, counter=0.
- Latency, start sampled at edge k:
  - busy is high in the cycles after edges k … k+13 (exactly 14 cycles)
  - busy falls and done rises after edge k+14, with binary_out valid in that same cycle
- Invalid-digit request sampled at edge k: done and error go high after edge k+1 (1-cycle latency); busy never asserts.
- done is high for exactly one cycle per accepted start.
- Back-to-back: start may be asserted in the cycle done is high, since the FSM is in IDLE. The new conversion begins at that edge with no bubble.
- rst=1 at any edge (including mid-CONV):
  - all outputs and state return to reset values at that edge
  - no done for the aborted conversion
  - rst has priority over start
- Arithmetic:
  - the nibble correction never underflows, because nibble ≥ 8 is checked before subtracting
  - the result is always ≤ 9999, so no overflow of 14 bits

## Test plan

- Digits 0,0,0,0, start at edge k → busy high 14 cycles; done after edge k+14; binary_out=0, error=0.
- Digits 9,9,9,9 → binary_out=9999 (14'h270F), done 14 cycles after start; then digits 1,2,3,4 issued in the done cycle → binary_out=1234 (14'h04D2) exactly 14 cycles later with no idle gap.
- Digits 0,5,0,8 → binary_out=508. Change the digit inputs to 7,7,7,7 mid-conversion → result is still 508.
- Digits 1,10,0,0 (hundreds=4'hA) → one cycle later done=1, error=1, binary_out=0, busy never high. Next valid request 0,0,4,2 → 42 with error=0.
- start pulsed repeatedly while busy → ignored; exactly one done pulse per accepted start.
- rst asserted at cycle 7 of a conversion of 8,1,9,2 → next cycle all outputs 0, no done pulse. A fresh start of 8,1,9,2 → 8192 (14'h2000).
